// File: rtl/clk_rst_seq_if.sv
// clk_rst_seq_if: request/strobe/reset bundle between the sequencer
// and the subsystems it releases.
interface clk_rst_seq_if #(
    parameter int N_RST = 3
);
    logic             rst_req;
    logic             wdt_kick;
    logic             clk_en;
    logic [N_RST-1:0] rst_out_n;
    logic             busy;
    logic [1:0]       rst_cause;

    modport master (
        input  rst_req,
        input  wdt_kick,
        output clk_en,
        output rst_out_n,
        output busy,
        output rst_cause
    );

    modport slave (
        output rst_req,
        output wdt_kick,
        input  clk_en,
        input  rst_out_n,
        input  busy,
        input  rst_cause
    );
endinterface

// File: rtl/clk_rst_seq.sv
// clk_rst_seq: clock-enable divider plus staggered reset sequencer.
// Define CLK_RST_SEQ_WDT_EN to build in the RUN-state watchdog.
module clk_rst_seq #(
    parameter int CLK_DIV    = 4,
    parameter int RST_CYCLES = 256,
    parameter int N_RST      = 3,
    parameter int STAGGER    = 16,
    parameter int WDT_BITS   = 20
) (
    input logic           clk,
    input logic           reset_n,
    clk_rst_seq_if.master bus
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW = $clog2(RST_CYCLES + 1);
    localparam int SL = (N_RST - 1) * STAGGER;
    localparam int SW = (SL > 0) ? $clog2(SL + 1) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES);
    localparam logic [SW-1:0] STAG_LAST = SW'(SL);

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        RUN
    } state_t;

    state_t           state;
    logic [DW-1:0]    div_cnt;
    logic [HW-1:0]    hold_cnt;
    logic [SW-1:0]    stag_cnt;
    logic [N_RST-1:0] rel_mask;
    logic             wdt_to;

    // Divider ignores internal resets so clk_en cadence survives them.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt    <= '0;
            bus.clk_en <= 1'b0;
        end else begin
            bus.clk_en <= (div_cnt == DIV_LAST);
            if (div_cnt == DIV_LAST)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;
        end
    end

    always_comb begin
        rel_mask = '0;
        for (int i = 0; i < N_RST; i++)
            rel_mask[i] = (int'(stag_cnt) + 1) >= (i * STAGGER);
    end

`ifdef CLK_RST_SEQ_WDT_EN
    localparam logic [WDT_BITS-1:0] WDT_TERM = ~WDT_BITS'(1);

    logic [WDT_BITS-1:0] wdt_cnt;

    // Timeout fires on the edge the count would reach all-ones.
    assign wdt_to = (state == RUN) && !bus.wdt_kick
                 && (wdt_cnt == WDT_TERM);

    always_ff @(posedge clk) begin
        if (!reset_n || state != RUN || bus.wdt_kick || wdt_to)
            wdt_cnt <= '0;
        else
            wdt_cnt <= wdt_cnt + 1'b1;
    end
`else
    logic unused_wdt;

    assign wdt_to     = 1'b0;
    assign unused_wdt = bus.wdt_kick ^ (WDT_BITS > 0);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= HOLD;
            hold_cnt      <= '0;
            stag_cnt      <= '0;
            bus.rst_out_n <= '0;
            bus.busy      <= 1'b1;
            bus.rst_cause <= 2'b00;
        end else if (wdt_to) begin
            state         <= HOLD;
            hold_cnt      <= '0;
            stag_cnt      <= '0;
            bus.rst_out_n <= '0;
            bus.busy      <= 1'b1;
            bus.rst_cause <= 2'b10;
        end else if (bus.rst_req) begin
            state         <= HOLD;
            hold_cnt      <= '0;
            stag_cnt      <= '0;
            bus.rst_out_n <= '0;
            bus.busy      <= 1'b1;
            bus.rst_cause <= 2'b01;
        end else begin
            unique case (state)
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state         <= RELEASE;
                        stag_cnt      <= '0;
                        bus.rst_out_n <= N_RST'(1);
                        bus.busy      <= (N_RST > 1);
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (stag_cnt == STAG_LAST) begin
                        state <= RUN;
                    end else begin
                        stag_cnt      <= stag_cnt + 1'b1;
                        bus.rst_out_n <= rel_mask;
                        bus.busy      <= ~&rel_mask;
                    end
                end
                RUN: ;
                default: state <= HOLD;
            endcase
        end
    end
endmodule
